// File: rtl/prefetch_fetch.sv
// Instruction prefetch stage: issues one in-order fetch at a time into a small
// queue and presents the queue head to decode; redirects flush and retarget fetch.
module prefetch_fetch #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCsrc_E,
    input  logic [WIDTH-1:0] PCTarget_E,
    input  logic             stall_D,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             valid_F,
    output logic [WIDTH-1:0] instr_F,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] PCPlus4_F
);

    localparam int unsigned      PW  = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             full, accept, push, pop;
    logic [WIDTH-1:0] pc_head;

    assign full      = (count == (PW+1)'(DEPTH));
    // rst gates the request so nothing is presented while reset is held
    assign imem_req  = !rst && (state == S_REQ) && !PCsrc_E && !full;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign push      = (state == S_WAIT) && imem_rvalid && !PCsrc_E;
    assign pop       = valid_F && !stall_D && !PCsrc_E;

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (accept) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)  state_nxt = S_REQ;
                else if (PCsrc_E) state_nxt = S_DROP;
            end
            S_DROP:  if (imem_rvalid) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (PCsrc_E) begin
            fetch_pc <= PCTarget_E;
        end else if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (PCsrc_E) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign pc_head   = pc_mem[rd_ptr];
    assign valid_F   = (count != '0);
    assign instr_F   = valid_F ? instr_mem[rd_ptr] : NOP;
    assign PC_F      = valid_F ? pc_head : '0;
    assign PCPlus4_F = valid_F ? pc_head + WIDTH'(4) : '0;

endmodule
